// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the banked, writable instruction memory.
// Imported by the top level and by the bank storage array.
package inst_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Illegal/halt opcode. Returned for words that were never written or that lie out of range.
  localparam logic [7:0] FILL_INSTR_DEFAULT = 8'hFF;

  // True when {bank, addr} names an implemented word.
  function automatic logic in_range(input int unsigned bank,
                                    input int unsigned addr,
                                    input int unsigned num_banks,
                                    input int unsigned depth);
    return (bank < num_banks) && (addr < depth);
  endfunction

endpackage

// File: rtl/inst_mem_bank_array.sv
// Flat storage for all banks: one synchronous write port and one registered read port.
// A read of the word being written in the same cycle returns the new data.
module inst_mem_bank_array #(
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned WORDS   = 1024,
  parameter int unsigned IDX_W   = 10,
  parameter logic [INSTR_W-1:0] FILL = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [IDX_W-1:0]   raddr,
  input  logic               rfill,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [WORDS];

  // NOTE: the storage has no reset. It maps onto RAM, and the clear sweep initialises every word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // When re is low the read register holds, which gives the fetch stall its hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= FILL;
    end else if (re) begin
      if (rfill)
        rdata <= FILL;
      else if (we && (waddr == raddr))
        rdata <= wdata;
      else
        rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/inst_mem_banked.sv
// Banked, run-time loadable instruction memory. It has a registered fetch port with a stall hold
// and a hardware fill sweep that runs after reset or on a clear request.
module inst_mem_banked
  import inst_mem_pkg::*;
#(
  parameter int unsigned INSTR_W   = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter logic [INSTR_W-1:0] FILL_INSTR = INSTR_W'(FILL_INSTR_DEFAULT)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  output logic               busy_o,
  input  logic               fetch_req_i,
  input  logic [BANK_W-1:0]  fetch_bank_i,
  input  logic [ADDR_W-1:0]  fetch_addr_i,
  input  logic               stall_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  input  logic               load_en_i,
  input  logic [BANK_W-1:0]  load_bank_i,
  input  logic [ADDR_W-1:0]  load_addr_i,
  input  logic [INSTR_W-1:0] load_data_i,
  output logic               load_drop_o
);

  localparam int unsigned WORDS = NUM_BANKS * DEPTH;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  // The extra bit means the counter cannot wrap before the terminal compare.
  localparam int unsigned CNT_W = $clog2(WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready;
  logic               fetch_ok, load_ok;
  logic               read_fire, load_fire;
  logic [IDX_W-1:0]   fetch_idx, load_idx;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_waddr;
  logic [INSTR_W-1:0] mem_wdata;

  assign ready    = (state_q == READY);
  assign busy_o   = ~ready;
  assign fetch_ok = in_range(32'(fetch_bank_i), 32'(fetch_addr_i), NUM_BANKS, DEPTH);
  assign load_ok  = in_range(32'(load_bank_i), 32'(load_addr_i), NUM_BANKS, DEPTH);

  // Banks are packed back to back, so the flat index is bank*DEPTH + addr.
  assign fetch_idx = IDX_W'(32'(fetch_bank_i) * DEPTH + 32'(fetch_addr_i));
  assign load_idx  = IDX_W'(32'(load_bank_i) * DEPTH + 32'(load_addr_i));

  // A clear sampled in READY takes priority over that cycle's load and fetch.
  assign read_fire = ready && !clear_i && fetch_req_i && !stall_i;
  assign load_fire = ready && !clear_i && load_en_i && load_ok;

  // The sweep owns the write port for the whole time the block is not READY.
  assign mem_we    = !ready || load_fire;
  assign mem_waddr = ready ? load_idx : cnt_q[IDX_W-1:0];
  assign mem_wdata = ready ? load_data_i : FILL_INSTR;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= CLEAR;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets its default first, so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (!clear_i && (cnt_q == LAST)) state_d = READY;
      READY:   if (clear_i) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q         <= '0;
      instr_valid_o <= 1'b0;
      load_drop_o   <= 1'b0;
    end else begin
      cnt_q       <= (ready || clear_i) ? '0 : cnt_q + CNT_W'(1);
      load_drop_o <= load_en_i && !load_fire;
      if (ready && clear_i)
        instr_valid_o <= 1'b0;
      else if (!stall_i)
        instr_valid_o <= read_fire;
    end
  end

  inst_mem_bank_array #(
    .INSTR_W (INSTR_W),
    .WORDS   (WORDS),
    .IDX_W   (IDX_W),
    .FILL    (FILL_INSTR)
  ) u_array (
    .clk   (clk_i),
    .reset (reset_i),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (read_fire),
    .raddr (fetch_idx),
    .rfill (!fetch_ok),
    .rdata (instr_o)
  );

endmodule

// File: tb/tb_inst_mem_banked.sv
// Self-checking bench: a default instance and a DEPTH=200 instance share the same stimulus.
// Both are compared every cycle against a word-level reference model.
module tb_inst_mem_banked;

  localparam int NB = 4;
  localparam logic [7:0] FILL = 8'hFF;

  logic       clk = 1'b0;
  logic       reset_i, clear_i, fetch_req_i, stall_i, load_en_i;
  logic [1:0] fetch_bank_i, load_bank_i;
  logic [7:0] fetch_addr_i, load_addr_i, load_data_i;

  logic       busy  [2];
  logic       valid [2];
  logic       drop  [2];
  logic [7:0] instr [2];

  always #5 clk = ~clk;

  inst_mem_banked u_dut (
    .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .busy_o(busy[0]),
    .fetch_req_i(fetch_req_i), .fetch_bank_i(fetch_bank_i), .fetch_addr_i(fetch_addr_i),
    .stall_i(stall_i), .instr_o(instr[0]), .instr_valid_o(valid[0]),
    .load_en_i(load_en_i), .load_bank_i(load_bank_i), .load_addr_i(load_addr_i),
    .load_data_i(load_data_i), .load_drop_o(drop[0])
  );

  inst_mem_banked #(.DEPTH(200)) u_dut_d200 (
    .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .busy_o(busy[1]),
    .fetch_req_i(fetch_req_i), .fetch_bank_i(fetch_bank_i), .fetch_addr_i(fetch_addr_i),
    .stall_i(stall_i), .instr_o(instr[1]), .instr_valid_o(valid[1]),
    .load_en_i(load_en_i), .load_bank_i(load_bank_i), .load_addr_i(load_addr_i),
    .load_data_i(load_data_i), .load_drop_o(drop[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the memory contents, plus how many sweep cycles remain before the block is ready.
  logic [7:0] m_mem [2][NB][256];
  int         m_left  [2];
  logic [7:0] m_instr [2];
  logic       m_valid [2];
  logic       m_drop  [2];

  function automatic int dep(input int d);
    return (d == 0) ? 256 : 200;
  endfunction

  task automatic model_fill(input int d);
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 256; a++)
        m_mem[d][b][a] = FILL;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_left[d]  = NB * dep(d);
      m_instr[d] = FILL;
      m_valid[d] = 1'b0;
      m_drop[d]  = 1'b0;
      model_fill(d);
    end
  endtask

  task automatic model_step(input int d);
    int   dp       = dep(d);
    logic busy_now = (m_left[d] != 0);
    logic lin      = (int'(load_addr_i) < dp);
    m_drop[d] = load_en_i && (busy_now || clear_i || !lin);
    if (busy_now) begin
      if (clear_i) m_left[d] = NB * dp;
      else         m_left[d]--;
      if (!stall_i) m_valid[d] = 1'b0;
    end else if (clear_i) begin
      m_left[d]  = NB * dp;
      m_valid[d] = 1'b0;
      model_fill(d);
    end else begin
      if (load_en_i && lin) m_mem[d][load_bank_i][load_addr_i] = load_data_i;
      if (!stall_i) begin
        m_valid[d] = fetch_req_i;
        if (fetch_req_i)
          m_instr[d] = (int'(fetch_addr_i) < dp) ? m_mem[d][fetch_bank_i][fetch_addr_i] : FILL;
      end
    end
  endtask

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) model_reset();
    else for (int d = 0; d < 2; d++) model_step(d);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("busy[%0d]", d),  busy[d],  m_left[d] != 0);
        check($sformatf("valid[%0d]", d), valid[d], m_valid[d]);
        check($sformatf("instr[%0d]", d), instr[d], m_instr[d]);
        check($sformatf("drop[%0d]", d),  drop[d],  m_drop[d]);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Returns, per instance, the index of the first negedge at which busy is low (0 if the bound expires).
  task automatic wait_ready(output int i0, output int i1);
    int cyc = 0;
    i0 = 0;
    i1 = 0;
    while ((i0 == 0 || i1 == 0) && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (i0 == 0 && !busy[0]) i0 = cyc;
      if (i1 == 0 && !busy[1]) i1 = cyc;
    end
    #1;
  endtask

  task automatic load(input logic [1:0] b, input logic [7:0] a, input logic [7:0] v);
    load_en_i = 1'b1; load_bank_i = b; load_addr_i = a; load_data_i = v;
  endtask

  task automatic fetch(input logic [1:0] b, input logic [7:0] a);
    fetch_req_i = 1'b1; fetch_bank_i = b; fetch_addr_i = a;
  endtask

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 8'($urandom_range(0, 7));
      6:       return 8'hC7;
      7:       return 8'hC8;
      8:       return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int i0, i1;
    reset_i = 1'b1; clear_i = 1'b0; stall_i = 1'b0; load_en_i = 1'b0;
    load_bank_i = '0; load_addr_i = '0; load_data_i = '0;
    fetch_req_i = 1'b1; fetch_bank_i = 2'd2; fetch_addr_i = 8'h10;
    model_reset();
    step();
    cmp_en = 1'b1;
    repeat (2) step();
    reset_i = 1'b0;

    // Power-up sweep: 4*256 and 4*200 cycles, fetches ignored throughout.
    wait_ready(i0, i1);
    check("sweep_len_reset", i0, 1024);
    check("sweep_len_reset_d200", i1, 800);
    check("first_ready_valid", valid[0], 1'b0);
    step();
    check("first_fetch_valid", valid[0], 1'b1);
    check("first_fetch_fill", instr[0], FILL);

    fetch_req_i = 1'b0;
    load(2'd1, 8'h03, 8'h11); step();
    load(2'd0, 8'h03, 8'hC0); step();
    load(2'd0, 8'h05, 8'h22); step();
    load(2'd0, 8'h06, 8'h33); step();
    load_en_i = 1'b0;
    fetch(2'd1, 8'h03); step();
    check("bank1_03", instr[0], 8'h11);
    fetch(2'd0, 8'h03); step();
    check("bank0_03", instr[0], 8'hC0);
    fetch(2'd0, 8'h05); step();
    check("pre_stall", instr[0], 8'h22);

    stall_i = 1'b1;
    fetch(2'd0, 8'h06);
    repeat (3) begin
      step();
      check("stall_hold_instr", instr[0], 8'h22);
      check("stall_hold_valid", valid[0], 1'b1);
    end
    stall_i = 1'b0;
    step();
    check("after_stall", instr[0], 8'h33);

    load(2'd0, 8'h07, 8'h5A); fetch(2'd0, 8'h07); step();
    check("write_first", instr[0], 8'h5A);
    check("write_first_d200", instr[1], 8'h5A);

    fetch_req_i = 1'b0;
    load(2'd0, 8'hC8, 8'h77); step();
    check("oor_load_drop_d200", drop[1], 1'b1);
    check("inrange_load_nodrop", drop[0], 1'b0);
    load_en_i = 1'b0;
    fetch(2'd0, 8'hC8); step();
    check("oor_fetch_d200", instr[1], FILL);
    check("oor_fetch_valid_d200", valid[1], 1'b1);
    check("drop_is_pulse_d200", drop[1], 1'b0);
    check("inrange_fetch", instr[0], 8'h77);

    // Random traffic, concentrated on a few addresses so that collisions and range edges are hit.
    for (int n = 0; n < 2500; n++) begin
      fetch_req_i  = ($urandom_range(0, 3) != 0);
      fetch_bank_i = 2'($urandom_range(0, 3));
      fetch_addr_i = rand_addr();
      stall_i      = ($urandom_range(0, 4) == 0);
      load_en_i    = ($urandom_range(0, 2) == 0);
      load_bank_i  = 2'($urandom_range(0, 3));
      load_addr_i  = rand_addr();
      load_data_i  = 8'($urandom);
      clear_i      = ($urandom_range(0, 799) == 0);
      step();
    end
    clear_i = 1'b0; stall_i = 1'b0; load_en_i = 1'b0; fetch_req_i = 1'b0;
    wait_ready(i0, i1);

    // Clear from READY: the load sampled together with clear is dropped, and everything reads back as fill.
    load(2'd3, 8'h01, 8'h11); step();
    clear_i = 1'b1;
    load(2'd2, 8'h02, 8'h99); step();
    clear_i = 1'b0; load_en_i = 1'b0;
    check("clear_load_drop", drop[0], 1'b1);
    check("clear_busy", busy[0], 1'b1);
    wait_ready(i0, i1);
    check("sweep_len_clear", i0, 1024);
    check("sweep_len_clear_d200", i1, 800);
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < 256; a++) begin
        fetch(2'(b), 8'(a)); step();
        check("post_clear_fill", instr[0], FILL);
      end
    end

    // Reset while fetching: the outputs drop at once, and the sweep starts over.
    check("pre_reset_valid", valid[0], 1'b1);
    reset_i = 1'b1; #1;
    check("reset_valid_now", valid[0], 1'b0);
    check("reset_busy_now", busy[0], 1'b1);
    step();
    reset_i = 1'b0;
    wait_ready(i0, i1);
    check("sweep_len_reset2", i0, 1024);

    // Reset mid-sweep: the full sweep length proves the counter restarted from 0.
    fetch_req_i = 1'b0;
    clear_i = 1'b1; step();
    clear_i = 1'b0;
    load(2'd0, 8'h09, 8'hAB); step();
    check("sweep_load_drop", drop[0], 1'b1);
    load_en_i = 1'b0;
    repeat (50) step();
    reset_i = 1'b1; #1;
    check("midsweep_reset_valid", valid[0], 1'b0);
    check("midsweep_reset_instr", instr[0], FILL);
    step();
    reset_i = 1'b0;
    wait_ready(i0, i1);
    check("sweep_len_midsweep", i0, 1024);
    check("sweep_len_midsweep_d200", i1, 800);
    fetch(2'd0, 8'h09); step();
    check("sweep_load_not_written", instr[0], FILL);
    fetch_req_i = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
